// File: rtl/aukv_eggs_pkg.sv
// aukv_eggs_pkg: opcodes, UART FSM states and framing option (AUKV_EGGS_PARITY_EN selects 8E1).
package aukv_eggs_pkg;
  localparam logic [2:0] OP_SET_LED = 3'b001;
  localparam logic [2:0] OP_QUERY   = 3'b010;
  localparam logic [2:0] OP_STATUS  = 3'b100;
`ifdef AUKV_EGGS_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/aukv_eggs_uart.sv
// aukv_eggs_uart: full-duplex byte UART with rx synchronizer, glitch filter and framing-error lockout.
module aukv_eggs_uart
  import aukv_eggs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       tx_busy,
  output logic       rx_valid,
  output logic [7:0] rx_byte
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  tx_state_t ts;
  rx_state_t rs;
  logic [CW-1:0] tcnt, rcnt;
  logic [2:0] tidx, ridx;
  logic [7:0] tsh, rsh;
  logic tpar, rpar_ok, rx_m, rx_s, rx_p, tend, rend;
  assign tend = tcnt == CW'(CLKS_PER_BIT - 1);
  assign rend = rcnt == CW'(CLKS_PER_BIT - 1);
  assign tx_busy = ts != TX_IDLE;
  assign rx_byte = rsh;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ts <= TX_IDLE;
      tx <= 1'b1;
      tcnt <= '0;
      tidx <= '0;
      tsh <= '0;
      tpar <= 1'b0;
    end else if (ts == TX_IDLE) begin
      if (tx_start) begin
        ts <= TX_START;
        tx <= 1'b0;
        tcnt <= '0;
        tsh <= tx_byte;
        tpar <= ^tx_byte;
      end
    end else if (!tend) tcnt <= tcnt + 1'b1;
    else begin
      tcnt <= '0;
      case (ts)
        TX_START: begin
          ts <= TX_DATA;
          tx <= tsh[0];
          tsh <= tsh >> 1;
          tidx <= '0;
        end
        TX_DATA:
          if (tidx != 3'd7) begin
            tx <= tsh[0];
            tsh <= tsh >> 1;
            tidx <= tidx + 1'b1;
          end else begin
            ts <= PARITY_EN ? TX_PARITY : TX_STOP;
            tx <= PARITY_EN ? tpar : 1'b1;
          end
        TX_PARITY: begin
          ts <= TX_STOP;
          tx <= 1'b1;
        end
        default: ts <= TX_IDLE;
      endcase
    end
  // start is confirmed at half a bit, so every later sample lands at bit centre
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
      rs <= RX_IDLE;
      rcnt <= '0;
      ridx <= '0;
      rsh <= '0;
      rpar_ok <= 1'b1;
      rx_valid <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
      rx_valid <= 1'b0;
      rcnt <= rcnt + 1'b1;
      case (rs)
        RX_IDLE: begin
          rcnt <= '0;
          if (rx_p && !rx_s) rs <= RX_START;
        end
        RX_START:
          if (rcnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
            rcnt <= '0;
            ridx <= '0;
            rpar_ok <= 1'b1;
            rs <= rx_s ? RX_IDLE : RX_DATA;
          end
        RX_DATA:
          if (rend) begin
            rcnt <= '0;
            rsh <= {rx_s, rsh[7:1]};
            ridx <= ridx + 1'b1;
            if (ridx == 3'd7) rs <= PARITY_EN ? RX_PARITY : RX_STOP;
          end
        RX_PARITY:
          if (rend) begin
            rcnt <= '0;
            rpar_ok <= rx_s == ^rsh;
            rs <= RX_STOP;
          end
        RX_STOP:
          if (rend) begin
            rcnt <= '0;
            rx_valid <= rx_s && rpar_ok;
            rs <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
          end
        default: if (rx_s) rs <= RX_IDLE;
      endcase
    end
endmodule

// File: rtl/aukv_eggs_soc_lite.sv
// aukv_eggs_soc_lite: UART command/status SoC driving LEDs and reporting switches (AUKV_EGGS_PARITY_EN: 8E1 framing).
module aukv_eggs_soc_lite
  import aukv_eggs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_tx,
  output logic [2:0] o_led,
  input  logic [4:0] i_switch
);
  logic [4:0] sw_m, sw_s, sw_p;
  logic [1:0] boot;
  logic [7:0] rx_byte;
  logic [1:0] unused_rsv;
  logic pending, go, tx_busy, rx_valid, is_led, is_query;
  assign go = pending && boot == 2'd3 && !tx_busy;
  assign is_led = rx_valid && (rx_byte[7:5] == OP_SET_LED || rx_byte[7:5] == OP_STATUS);
  assign is_query = rx_valid && rx_byte[7:5] == OP_QUERY;
  assign unused_rsv = rx_byte[4:3];
  aukv_eggs_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk(i_clk),
    .rst(i_rst),
    .rx(i_rx),
    .tx_start(go),
    .tx_byte({OP_STATUS, sw_s}),
    .tx(o_tx),
    .tx_busy(tx_busy),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte)
  );
  // new triggers win over the launch clear so nothing arriving on the launch cycle is lost
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      sw_m <= '0;
      sw_s <= '0;
      sw_p <= '0;
      boot <= '0;
      pending <= 1'b1;
      o_led <= '0;
    end else begin
      sw_m <= i_switch;
      sw_s <= sw_m;
      sw_p <= sw_s;
      boot <= boot + {1'b0, boot != 2'd3};
      pending <= (sw_s != sw_p) || is_query || (pending && !go);
      o_led <= is_led ? rx_byte[2:0] : o_led;
    end
endmodule

// File: tb/tb_aukv_eggs_soc_lite.sv
// tb_aukv_eggs_soc_lite: directed bench with UART line monitors feeding an LED/status-frame model.
module tb_aukv_eggs_soc_lite;
  localparam int CPB = 16;
`ifdef AUKV_EGGS_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, loop = 1'b1, drv_rx = 1'b1;
  logic [4:0] sw = 5'h05;
  logic tx, rx_line;
  logic [2:0] led;
  logic [2:0] want_led = 3'b000;
  logic [7:0] exp_tx[$];
  logic [7:0] last_tx = 8'h00;
  bit chk_led = 1'b1;
  int tests = 0, fails = 0, n_frames = 0;
  assign rx_line = loop ? tx : drv_rx;
  always #5 clk = ~clk;
  aukv_eggs_soc_lite #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx(rx_line),
    .o_tx(tx),
    .o_led(led),
    .i_switch(sw)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask
  task automatic wcyc(input int n, inout bit ab);
    for (int i = 0; i < n && !ab; i++) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask
  function automatic logic line(input bit use_tx);
    return use_tx ? tx : rx_line;
  endfunction
  // reads one frame after its falling edge; ok=0 for a glitch or a reset abort
  task automatic frame(input bit use_tx, output bit ok, output logic [7:0] b, output bit good_par,
                       output bit stop, inout bit ab);
    ok = 1'b0;
    b = 8'h00;
    good_par = 1'b1;
    stop = 1'b0;
    wcyc(CPB / 2, ab);
    if (ab || line(use_tx)) return;
    for (int k = 0; k < 8; k++) begin
      wcyc(CPB, ab);
      b[k] = line(use_tx);
    end
    if (PAR) begin
      wcyc(CPB, ab);
      good_par = line(use_tx) == ^b;
    end
    wcyc(CPB, ab);
    stop = line(use_tx);
    ok = !ab;
  endtask
  task automatic apply(input logic [7:0] b);
    if (b[7:5] == 3'b001 || b[7:5] == 3'b100) want_led = b[2:0];
    else if (b[7:5] == 3'b010) exp_tx.push_back({3'b100, sw});
  endtask
  initial begin : rx_mon
    bit p, ab, ok, gp, st;
    logic [7:0] b;
    p = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && p && !rx_line) begin
        chk_led = 1'b0;
        ab = 1'b0;
        frame(1'b0, ok, b, gp, st, ab);
        if (ok && st) begin
          wcyc(CPB / 2, ab);
          if (!ab && gp) apply(b);
        end else if (ok) while (!ab && !rx_line) wcyc(1, ab);
        chk_led = 1'b1;
      end
      p = rst ? 1'b1 : rx_line;
    end
  end
  initial begin : tx_mon
    bit p, ab, ok, gp, st;
    logic [7:0] b;
    p = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && p && !tx) begin
        ab = 1'b0;
        frame(1'b1, ok, b, gp, st, ab);
        if (ok) begin
          n_frames++;
          last_tx = b;
          chk("tx_stop_bit", {31'd0, st}, 32'd1);
`ifdef AUKV_EGGS_PARITY_EN
          chk("tx_parity", {31'd0, gp}, 32'd1);
`endif
          if (exp_tx.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_unexpected: got frame 0x%02h, expected no frame", b);
          end else chk("tx_byte", {24'd0, b}, {24'd0, exp_tx.pop_front()});
        end
      end
      p = rst ? 1'b1 : tx;
    end
  end
  always @(negedge clk) if (chk_led) chk("led_model", {29'd0, led}, {29'd0, want_led});
  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 drv_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      #1 drv_rx = b[k];
      repeat (CPB) @(posedge clk);
    end
    if (PAR) begin
      #1 drv_rx = ^b;
      repeat (CPB) @(posedge clk);
    end
    #1 drv_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
  endtask
  task automatic drain(input int budget);
    int i = 0;
    while (exp_tx.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("tx_drain", exp_tx.size(), 0);
    repeat (2 * CPB) @(negedge clk);
  endtask
  task automatic idle();
    repeat (25 * CPB) @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end
  initial begin
    int n, f0;
    exp_tx.push_back(8'h85);
    repeat (25) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (tx && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("t1_start_delay_ok", {31'd0, n >= 3 && n <= 4}, 32'd1);
    repeat (166 - n) @(posedge clk);
    #1 chk("t1_led", {29'd0, led}, 32'd5);
    drain(400);
    idle();
    chk("t1_frames", n_frames, 1);
    chk("t1_byte", {24'd0, last_tx}, 32'h85);
    loop = 1'b0;
    f0 = n_frames;
    send(8'h26);
    chk("t2_led", {29'd0, led}, 32'd6);
    idle();
    chk("t2_no_tx", n_frames - f0, 0);
    sw = 5'h1F;
    exp_tx.push_back(8'h9F);
    drain(600);
    idle();
    f0 = n_frames;
    send(8'h40);
    drain(600);
    idle();
    chk("t3_query_frames", n_frames - f0, 1);
    chk("t3_byte", {24'd0, last_tx}, 32'h9F);
    chk("t3_led_kept", {29'd0, led}, 32'd6);
    sw = 5'h05;
    exp_tx.push_back(8'h85);
    drain(600);
    idle();
    f0 = n_frames;
    sw = 5'h0A;
    exp_tx.push_back(8'h8A);
    repeat (30) @(negedge clk);
    sw = 5'h03;
    exp_tx.push_back(8'h83);
    drain(800);
    idle();
    chk("t4_frames", n_frames - f0, 2);
    chk("t4_byte", {24'd0, last_tx}, 32'h83);
    @(posedge clk);
    #1 drv_rx = 1'b0;
    repeat (40 * CPB) @(posedge clk);
    #1 drv_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    chk("t5_led_hold", {29'd0, led}, 32'd6);
    send(8'h21);
    chk("t5_led", {29'd0, led}, 32'd1);
    loop = 1'b1;
    sw = 5'h16;
    exp_tx.push_back(8'h96);
    n = 0;
    while (tx && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("t6_frame_started", {31'd0, tx}, 32'd0);
    repeat (40) @(posedge clk);
    #2 rst = 1'b1;
    want_led = 3'b000;
    exp_tx.delete();
    #1 chk("t6_tx_reset", {31'd0, tx}, 32'd1);
    chk("t6_led_reset", {29'd0, led}, 32'd0);
    exp_tx.push_back(8'h96);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    drain(600);
    idle();
    chk("t6_byte", {24'd0, last_tx}, 32'h96);
    chk("t6_led_mirror", {29'd0, led}, 32'd6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aukv_eggs_soc_lite.md
Name: aukv_eggs_soc_lite

Overview:
- Minimal board-level "eggs" SoC: a UART command/status engine driving 3 LEDs and reporting 5 slide switches.
- Receives single-byte commands on a UART RX line and transmits single-byte status frames on UART TX.
- Sits at the FPGA top, directly on board pins.
- Self-test: with TX looped back to RX, the LEDs mirror switch[2:0].

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 4.

Ports:
- i_clk  in  1  system clock, rising-edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx  in  1  UART receive line, idle high, asynchronous to i_clk.
- o_tx  out  1  UART transmit line, idle high.
- o_led  out  3  LED drive, 1 = on.
- i_switch  in  5  slide switches, asynchronous to i_clk.

Behaviour:
- Reset values:
  - o_tx = 1, o_led = 0.
  - TX/RX FSMs in IDLE; status_pending = 1; startup counter = 0.
  - Synchronizer flops: i_rx sync = 1, i_switch sync = 0.
- Reset mid-frame: o_tx goes high immediately (async) and the frame is abandoned; a partial RX byte is discarded.
- Synchronizers: i_rx and i_switch each pass through 2 flops; all logic uses the synced values.
- Frame format: 8N1, LSB first; start bit 0, 8 data bits, stop bit 1; each bit lasts CLKS_PER_BIT cycles.
- TX FSM, states IDLE → START → DATA(8) → STOP → IDLE:
  - From IDLE, when status_pending = 1 and the startup counter has reached 3 (3 cycles after reset release):
    - latch byte = {3'b100, switch_sync};
    - clear status_pending;
    - drive the start bit on the next cycle.
  - Switch value is latched at frame start; changes during a frame do not alter it.
- Status triggers (each sets status_pending):
  - reset;
  - any change of switch_sync versus its value on the previous cycle;
  - receipt of a query command.
  - Multiple triggers while busy or pending collapse into one frame carrying the value latched at that frame's start.
- RX FSM, states IDLE → START → DATA → STOP → (WAIT_HIGH) → IDLE:
  - Start: falling edge of rx_sync detected in IDLE.
  - At CLKS_PER_BIT/2, rx_sync must still be 0, else return to IDLE (glitch).
  - Data bits are sampled every CLKS_PER_BIT cycles at bit centre.
  - Stop bit sampled = 1: byte valid for one cycle.
  - Stop bit sampled = 0 (framing error): drop the byte, go to WAIT_HIGH, re-arm only after rx_sync = 1. A line held low never produces a byte.
- Command decode on a valid byte, by byte[7:5]:
  - 3'b001 (SET_LED): o_led <= byte[2:0].
  - 3'b100 (STATUS, loopback mirror): o_led <= byte[2:0].
  - 3'b010 (QUERY): status_pending <= 1.
  - All other opcodes are ignored.
- o_led updates on the cycle after the valid strobe.
- RX and TX run independently (full duplex); a valid command and a switch change in the same cycle are both honoured.

Optional Feature:
- Macro AUKV_EGGS_PARITY_EN.
- When defined:
  - frames are 8E1 (even parity bit between data and stop);
  - TX generates parity;
  - RX drops a byte with bad parity (no LED change, no query), then returns to IDLE normally.
- When undefined: pure 8N1 as above.

Decomposition:
- Package aukv_eggs_pkg holds:
  - opcode constants OP_SET_LED = 3'b001, OP_QUERY = 3'b010, OP_STATUS = 3'b100;
  - TX and RX state enumerations.
- One natural sub-module: aukv_eggs_uart (baud counters, TX/RX FSMs, synchronizer).
- Top level holds the switch change detector, the pending flag and the command decoder.

Test Plan:
1. Run with CLKS_PER_BIT = 16, i_switch = 5'h05, o_tx looped to i_rx, reset for 25 cycles. Required:
   - o_tx frame = 0x85, start bit 3 cycles after release;
   - o_led = 3'b101 after the frame's stop bit (≈ 10×16 + 6 cycles);
   - no further frames.
2. Drive i_rx externally with 0x26 (SET_LED). Required: o_led = 3'b110; no TX activity.
3. Drive i_rx with 0x40 (QUERY) while i_switch = 5'h1F. Required: o_tx emits 0x9F exactly once.
4. Change i_switch 5'h05 → 5'h0A → 5'h03 within one TX frame. Required: the current frame completes, then exactly one frame 0x83 follows.
5. Hold i_rx = 0 for 40 bit times, then release. Required:
   - no LED change;
   - a following valid 0x21 sets o_led = 3'b001.
6. Assert i_rst mid-TX-frame. Required:
   - o_tx = 1 and o_led = 0 immediately;
   - after release, a new status frame starts.
